lisnoc_router_output_arbiter: RTL

LISNOC_ROUTER_OUTPUT_ARBITER -- requirements
Module: lisnoc_router_output_arbiter

---
 rtl/lisnoc_router_output_arbiter_if.sv | 25 ++
 rtl/lisnoc_router_output_arbiter.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/lisnoc_router_output_arbiter_if.sv
// Handshake bundle between the per-port input buffers, the output arbiter and the output link.
interface lisnoc_router_output_arbiter_if #(
  parameter int flit_data_width = 32,
  parameter int flit_type_width = 2,
  parameter int ports           = 5
);
  localparam int flit_width = flit_data_width + flit_type_width;

  logic [ports*flit_width-1:0] flit_i;
  logic [ports-1:0]            request_i;
  logic [ports-1:0]            read_o;
  logic [flit_width-1:0]       flit_o;
  logic                        valid_o;
  logic                        ready_i;

  modport slave (
    input  flit_i, request_i, ready_i,
    output read_o, flit_o, valid_o
  );

  modport master (
    output flit_i, request_i, ready_i,
    input  read_o, flit_o, valid_o
  );
endinterface

// File: rtl/lisnoc_router_output_arbiter.sv
// Wormhole output arbiter: round-robin packet grant, zero-latency forwarding.
// Optional packet counter output packets_o enabled by LISNOC_OUTARB_STATS_EN.
module lisnoc_router_output_arbiter #(
  parameter int flit_data_width = 32,
  parameter int flit_type_width = 2,
  parameter int ports           = 5
) (
  input  logic clk,
  input  logic rst,
  lisnoc_router_output_arbiter_if.slave bus
`ifdef LISNOC_OUTARB_STATS_EN
  ,
  output logic [15:0] packets_o
`endif
);
  localparam int flit_width = flit_data_width + flit_type_width;
  localparam int owner_w    = (ports > 1) ? $clog2(ports) : 1;

  localparam logic [flit_type_width-1:0] TYPE_PAYLOAD = flit_type_width'(2'b00);
  localparam logic [flit_type_width-1:0] TYPE_HEAD    = flit_type_width'(2'b01);
  localparam logic [flit_type_width-1:0] TYPE_TAIL    = flit_type_width'(2'b10);
  localparam logic [flit_type_width-1:0] TYPE_SINGLE  = flit_type_width'(2'b11);

  typedef enum logic [1:0] {IDLE, HEAD_WAIT, PACKET} state_t;

  state_t                      state;
  logic [owner_w-1:0]          owner;
  logic [owner_w-1:0]          last_winner;

  logic [ports-1:0]            elig;
  logic                        found;
  logic [owner_w-1:0]          winner;
  logic                        grant_vld;
  logic [owner_w-1:0]          grant_idx;
  logic [flit_width-1:0]       sel_flit;
  logic [flit_type_width-1:0]  grant_type;
  logic                        xfer;

  // Only packet starters may win arbitration in IDLE
  always_comb begin
    elig = '0;
    for (int p = 0; p < ports; p++) begin
      logic [flit_type_width-1:0] typ;
      typ = bus.flit_i[p*flit_width+flit_data_width +: flit_type_width];
      elig[p] = bus.request_i[p] && ((typ == TYPE_HEAD) || (typ == TYPE_SINGLE));
    end
  end

  always_comb begin
    logic [owner_w-1:0] cand;
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int i = 1; i <= ports; i++) begin
      cand = owner_w'((int'(last_winner) + i) % ports);
      if (!found && elig[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  // Output mux; reset gates everything so a held-off packet disappears at once
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = owner;
    unique case (state)
      IDLE: begin
        grant_vld = found;
        grant_idx = winner;
      end
      HEAD_WAIT, PACKET: grant_vld = bus.request_i[owner];
      default: grant_vld = 1'b0;
    endcase
    if (!rst) grant_vld = 1'b0;

    sel_flit = '0;
    for (int p = 0; p < ports; p++) begin
      if (p == int'(grant_idx)) sel_flit = bus.flit_i[p*flit_width +: flit_width];
    end

    bus.valid_o = grant_vld;
    bus.flit_o  = grant_vld ? sel_flit : '0;
    bus.read_o  = '0;
    for (int p = 0; p < ports; p++) begin
      bus.read_o[p] = grant_vld && bus.ready_i && (p == int'(grant_idx));
    end

    grant_type = sel_flit[flit_width-1 -: flit_type_width];
    xfer       = grant_vld && bus.ready_i;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      owner       <= '0;
      last_winner <= owner_w'(ports - 1);
    end else begin
      unique case (state)
        IDLE: begin
          if (grant_vld) begin
            if (!bus.ready_i) begin
              state <= HEAD_WAIT;
              owner <= winner;
            end else if (grant_type == TYPE_SINGLE) begin
              last_winner <= winner;
            end else begin
              state <= PACKET;
              owner <= winner;
            end
          end
        end
        HEAD_WAIT: begin
          if (xfer) begin
            if ((grant_type == TYPE_SINGLE) || (grant_type == TYPE_TAIL)) begin
              state       <= IDLE;
              last_winner <= owner;
            end else begin
              state <= PACKET;
            end
          end
        end
        PACKET: begin
          if (xfer && (grant_type == TYPE_TAIL)) begin
            state       <= IDLE;
            last_winner <= owner;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef LISNOC_OUTARB_STATS_EN
  logic [15:0] pkt_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pkt_cnt <= '0;
    end else if (xfer && ((grant_type == TYPE_TAIL) || (grant_type == TYPE_SINGLE))
                 && (pkt_cnt != 16'hFFFF)) begin
      pkt_cnt <= pkt_cnt + 16'd1;
    end
  end

  assign packets_o = pkt_cnt;
`endif

  logic unused_payload_code;
  assign unused_payload_code = ^TYPE_PAYLOAD;
endmodule
